// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// UART receiver with 2-of-3 mid-bit voting, optional parity, 1/2 stop bits and
// error flags, feeding a first-word-fall-through FIFO on a valid/ready stream.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVS        = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        rx_busy,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overrun_err,
    input  logic                        err_clr
);
    localparam int DIV   = CLK_HZ / (BAUD * OVS);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TIX_W = $clog2(OVS);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [TIX_W-1:0] SAMP0 = TIX_W'(OVS / 2 - 1);
    localparam logic [TIX_W-1:0] SAMP1 = TIX_W'(OVS / 2);
    localparam logic [TIX_W-1:0] SAMP2 = TIX_W'(OVS / 2 + 1);
    localparam logic [TIX_W-1:0] LAST  = TIX_W'(OVS - 1);
    localparam logic             PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
    } state_t;

    logic                 sync_q, rx_s_q;
    logic [DIV_W-1:0]     div_q;
    state_t               state_q;
    logic [TIX_W-1:0]     tix_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 s0_q, s1_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bad_q, parity_err_q, frame_err_q, overrun_q;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_q, rd_q, rd_next;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_BITS-1:0] m_data_q;

    logic tick_w, at_mid_w, at_end_w, vote_w, last_stop_w, mismatch_w;
    logic push_w, pop_w, full_w, wr_w;

    assign tick_w      = (div_q == DIV_W'(DIV - 1));
    assign at_mid_w    = tick_w && (tix_q == SAMP2);
    assign at_end_w    = tick_w && (tix_q == LAST);
    assign vote_w      = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
    assign last_stop_w = (stop_cnt_q == 1'(STOP_BITS - 1));
    assign mismatch_w  = (((^shift_q) ^ vote_w) != PAR_ODD);
    assign push_w      = (state_q == ST_STOP) && at_mid_w && vote_w && last_stop_w && !par_bad_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
            div_q  <= '0;
        end else begin
            sync_q <= rx;
            rx_s_q <= sync_q;
            div_q  <= tick_w ? '0 : div_q + DIV_W'(1);
        end
    end

    // Decisions are taken at the third vote sample; bit changes happen at the bit end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            tix_q        <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (state_q != ST_IDLE && tick_w) begin
                tix_q <= (tix_q == LAST) ? '0 : tix_q + TIX_W'(1);
                if (tix_q == SAMP0) s0_q <= rx_s_q;
                if (tix_q == SAMP1) s1_q <= rx_s_q;
            end
            case (state_q)
                ST_IDLE: if (!rx_s_q) begin
                    state_q    <= ST_START;
                    tix_q      <= '0;
                    bit_cnt_q  <= '0;
                    stop_cnt_q <= 1'b0;
                    par_bad_q  <= 1'b0;
                end
                ST_START: begin
                    if (at_mid_w && vote_w) state_q <= ST_IDLE;
                    else if (at_end_w)      state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (at_mid_w) begin
                        shift_q   <= {vote_w, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                    if (at_end_w && bit_cnt_q == BIT_W'(DATA_BITS))
                        state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: begin
                    if (at_mid_w)      par_bad_q <= mismatch_w;
                    else if (at_end_w) state_q   <= ST_STOP;
                end
                ST_STOP: begin
                    if (at_mid_w) begin
                        if (!vote_w) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_IDLE;
                        end else if (last_stop_w) begin
                            parity_err_q <= par_bad_q;
                            state_q      <= ST_IDLE;
                        end
                    end else if (at_end_w) begin
                        stop_cnt_q <= 1'b1;
                    end
                end
                ST_WAIT_IDLE: if (rx_s_q) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pop_w   = (count_q != '0) && m_ready;
    assign full_w  = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_w    = push_w && (!full_w || pop_w);
    assign count_d = count_q + CNT_W'(wr_w) - CNT_W'(pop_w);
    assign rd_next = rd_q + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (wr_w) mem_q[wr_q] <= shift_q;
    end

    // m_data is a head register so it keeps the last word once the FIFO drains.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            m_data_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_w)  wr_q <= wr_q + PTR_W'(1);
            if (pop_w) rd_q <= rd_next;
            count_q <= count_d;
            if (push_w && !wr_w) overrun_q <= 1'b1;
            else if (err_clr)    overrun_q <= 1'b0;
            if (pop_w) begin
                if (count_q > CNT_W'(1)) m_data_q <= mem_q[rd_next];
                else if (wr_w)           m_data_q <= shift_q;
            end else if (count_q == '0 && wr_w) begin
                m_data_q <= shift_q;
            end
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = (count_q != '0);
    assign fifo_count  = count_q;
    assign rx_busy     = (state_q != ST_IDLE);
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_fifo: one 8N1 instance and one 8E1 instance,
// 160 clk per bit, 4-entry FIFO.
module tb_uart_rx_fifo;
    localparam int BIT_CLK = 160;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_line = 1'b1;
    logic sel = 1'b0;
    logic rx0, rx2;
    logic m_ready0 = 1'b0, m_ready2 = 1'b0, err_clr0 = 1'b0, err_clr2 = 1'b0;
    logic [7:0] m_data0, m_data2;
    logic [2:0] fifo_count0, fifo_count2;
    logic m_valid0, m_valid2, rx_busy0, rx_busy2;
    logic parity_err0, parity_err2, frame_err0, frame_err2, overrun_err0, overrun_err2;

    int total = 0;
    int bad = 0;
    int pe0 = 0, fe0 = 0, pe2 = 0, fe2 = 0, busy_rise0 = 0;
    logic busy_prev0 = 1'b0;

    always #5 clk = ~clk;

    assign rx0 = sel ? 1'b1 : rx_line;
    assign rx2 = sel ? rx_line : 1'b1;

    uart_rx_fifo #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVS(16), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .reset(reset), .rx(rx0), .m_data(m_data0), .m_valid(m_valid0),
        .m_ready(m_ready0), .fifo_count(fifo_count0), .rx_busy(rx_busy0),
        .parity_err(parity_err0), .frame_err(frame_err0),
        .overrun_err(overrun_err0), .err_clr(err_clr0));

    uart_rx_fifo #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVS(16), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .reset(reset), .rx(rx2), .m_data(m_data2), .m_valid(m_valid2),
        .m_ready(m_ready2), .fifo_count(fifo_count2), .rx_busy(rx_busy2),
        .parity_err(parity_err2), .frame_err(frame_err2),
        .overrun_err(overrun_err2), .err_clr(err_clr2));

    always @(negedge clk) begin
        if (parity_err0) pe0 <= pe0 + 1;
        if (frame_err0)  fe0 <= fe0 + 1;
        if (parity_err2) pe2 <= pe2 + 1;
        if (frame_err2)  fe2 <= fe2 + 1;
        if (rx_busy0 && !busy_prev0) busy_rise0 <= busy_rise0 + 1;
        busy_prev0 <= rx_busy0;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_bit(input logic b);
        rx_line = b;
        repeat (BIT_CLK) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_en) send_bit(par_bit);
        send_bit(stop_bit);
        rx_line = 1'b1;
    endtask

    task automatic pop0();
        @(posedge clk);
        m_ready0 = 1'b1;
        @(posedge clk);
        m_ready0 = 1'b0;
    endtask

    task automatic pop2();
        @(posedge clk);
        m_ready2 = 1'b1;
        @(posedge clk);
        m_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (4) @(posedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (m_valid0 !== 1'b0 || fifo_count0 !== 3'd0) begin
            bad++;
            $display("FAIL reset_fifo got valid=%b count=%0d exp valid=0 count=0", m_valid0, fifo_count0);
        end
        total++;
        if (m_data0 !== 8'h00) begin
            bad++;
            $display("FAIL reset_data got=%h exp=00", m_data0);
        end
        total++;
        if ({rx_busy0, parity_err0, frame_err0, overrun_err0} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got busy/pe/fe/ov=%b exp=0000",
                     {rx_busy0, parity_err0, frame_err0, overrun_err0});
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_basic();
        int n;
        int pe_s, fe_s;
        bit seen;
        logic prev_busy;
        logic [7:0] d;
        d = 8'h41;
        pe_s = pe0;
        fe_s = fe0;
        @(posedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        rx_line = 1'b1;
        n = 9 * BIT_CLK;
        seen = 1'b0;
        prev_busy = 1'b0;
        while (!seen && n < 1800) begin
            @(negedge clk);
            n++;
            if (m_valid0) seen = 1'b1;
            else prev_busy = rx_busy0;
        end
        total++;
        if (!seen || n < 1534 || n > 1543) begin
            bad++;
            $display("FAIL basic_latency got cycle=%0d seen=%0b exp 1534..1543", n, seen);
        end
        total++;
        if (rx_busy0 !== 1'b0 || prev_busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy_edge got busy=%b prev=%b exp busy=0 prev=1", rx_busy0, prev_busy);
        end
        total++;
        if (m_data0 !== 8'h41 || fifo_count0 !== 3'd1) begin
            bad++;
            $display("FAIL basic_word got data=%h count=%0d exp data=41 count=1", m_data0, fifo_count0);
        end
        repeat (100) @(posedge clk);
        total++;
        if (pe0 != pe_s || fe0 != fe_s || overrun_err0 !== 1'b0) begin
            bad++;
            $display("FAIL basic_noerr got pe=%0d fe=%0d ov=%b exp pe=%0d fe=%0d ov=0",
                     pe0, fe0, overrun_err0, pe_s, fe_s);
        end
        pop0();
        @(negedge clk);
        total++;
        if (m_valid0 !== 1'b0 || fifo_count0 !== 3'd0) begin
            bad++;
            $display("FAIL basic_pop got valid=%b count=%0d exp valid=0 count=0", m_valid0, fifo_count0);
        end
    endtask

    task automatic test_false_start();
        int br_s, pe_s, fe_s;
        @(posedge clk);
        br_s = busy_rise0;
        pe_s = pe0;
        fe_s = fe0;
        rx_line = 1'b0;
        repeat (40) @(posedge clk);
        rx_line = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy_rise0 != br_s + 1 || rx_busy0 !== 1'b0) begin
            bad++;
            $display("FAIL false_start_busy got rises=%0d busy=%b exp rises=%0d busy=0",
                     busy_rise0 - br_s, rx_busy0, 1);
        end
        total++;
        if (fifo_count0 !== 3'd0 || pe0 != pe_s || fe0 != fe_s) begin
            bad++;
            $display("FAIL false_start_quiet got count=%0d pe=%0d fe=%0d exp count=0 pe=%0d fe=%0d",
                     fifo_count0, pe0, fe0, pe_s, fe_s);
        end
    endtask

    task automatic test_parity();
        int pe_s, fe_s;
        sel = 1'b1;
        @(posedge clk);
        pe_s = pe2;
        fe_s = fe2;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (pe2 != pe_s + 1 || fe2 != fe_s || fifo_count2 !== 3'd0) begin
            bad++;
            $display("FAIL parity_bad got pe=%0d fe=%0d count=%0d exp pe=%0d fe=%0d count=0",
                     pe2 - pe_s, fe2 - fe_s, fifo_count2, 1, 0);
        end
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (pe2 != pe_s + 1 || fifo_count2 !== 3'd1 || m_data2 !== 8'h07) begin
            bad++;
            $display("FAIL parity_good got pe=%0d count=%0d data=%h exp pe=1 count=1 data=07",
                     pe2 - pe_s, fifo_count2, m_data2);
        end
        pop2();
        sel = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_break();
        int pe_s, fe_s, br_s;
        @(posedge clk);
        pe_s = pe0;
        fe_s = fe0;
        br_s = busy_rise0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(8'h55 >> i);
        rx_line = 1'b0;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        total++;
        if (rx_busy0 !== 1'b1 || fe0 != fe_s + 1 || pe0 != pe_s) begin
            bad++;
            $display("FAIL break_hold got busy=%b fe=%0d pe=%0d exp busy=1 fe=1 pe=0",
                     rx_busy0, fe0 - fe_s, pe0 - pe_s);
        end
        rx_line = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (rx_busy0 !== 1'b0 || fifo_count0 !== 3'd0 || fe0 != fe_s + 1 || busy_rise0 != br_s + 1) begin
            bad++;
            $display("FAIL break_release got busy=%b count=%0d fe=%0d rises=%0d exp 0 0 1 1",
                     rx_busy0, fifo_count0, fe0 - fe_s, busy_rise0 - br_s);
        end
        send_frame(8'h7A, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        total++;
        if (m_data0 !== 8'h7A || fifo_count0 !== 3'd1) begin
            bad++;
            $display("FAIL break_next got data=%h count=%0d exp data=7a count=1", m_data0, fifo_count0);
        end
        pop0();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        @(posedge clk);
        for (int i = 0; i < 5; i++) send_frame(8'h30 + 8'(i), 1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++;
        if (fifo_count0 !== 3'd4 || overrun_err0 !== 1'b1 || m_data0 !== 8'h30) begin
            bad++;
            $display("FAIL b2b_full got count=%0d ov=%b data=%h exp count=4 ov=1 data=30",
                     fifo_count0, overrun_err0, m_data0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'h30 + 8'(i);
            @(negedge clk);
            total++;
            if (m_data0 !== exp_d || m_valid0 !== 1'b1) begin
                bad++;
                $display("FAIL b2b_pop%0d got data=%h valid=%b exp data=%h valid=1", i, m_data0, m_valid0, exp_d);
            end
            pop0();
        end
        @(negedge clk);
        total++;
        if (m_valid0 !== 1'b0 || fifo_count0 !== 3'd0 || m_data0 !== 8'h33 || overrun_err0 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_drained got valid=%b count=%0d data=%h ov=%b exp 0 0 33 1",
                     m_valid0, fifo_count0, m_data0, overrun_err0);
        end
        @(posedge clk);
        err_clr0 = 1'b1;
        @(posedge clk);
        err_clr0 = 1'b0;
        @(negedge clk);
        total++;
        if (overrun_err0 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_errclr got ov=%b exp ov=0", overrun_err0);
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(8'h99 >> i);
        reset = 1'b0;
        rx_line = 1'b1;
        repeat (2) @(posedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (m_valid0 !== 1'b0 || m_data0 !== 8'h00 || fifo_count0 !== 3'd0 || rx_busy0 !== 1'b0) begin
            bad++;
            $display("FAIL midreset_out got valid=%b data=%h count=%0d busy=%b exp 0 00 0 0",
                     m_valid0, m_data0, fifo_count0, rx_busy0);
        end
        repeat (300) @(posedge clk);
        @(negedge clk);
        total++;
        if (fifo_count0 !== 3'd0 || rx_busy0 !== 1'b0) begin
            bad++;
            $display("FAIL midreset_nopush got count=%0d busy=%b exp count=0 busy=0", fifo_count0, rx_busy0);
        end
        @(posedge clk);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        total++;
        if (m_data0 !== 8'h12 || fifo_count0 !== 3'd1) begin
            bad++;
            $display("FAIL midreset_next got data=%h count=%0d exp data=12 count=1", m_data0, fifo_count0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_parity();
        test_break();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
